i2s_dac_transmitter: RTL

- Drives an external audio DAC with standard Philips I2S: the opposite direction of the external ADC receive path on bclk_in, lrclk_in and dout_in.
- Accepts stereo samples from the transceiver audio path over the codebase stb/ack handshake.
- Holds one sample pair in a one-deep buffer and serialises it MSB-first.
- Generates mclk_out, bclk_out and lrclk_out as master; everything runs in the clk domain.

---
 rtl/i2s_dac_transmitter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/i2s_dac_transmitter.sv
// I2S master transmitter for an external audio DAC: one-deep stereo buffer on an
// stb/ack handshake, MSB-first serialisation, and mclk/bclk/lrclk generation.
module i2s_dac_transmitter #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int SLOT_BITS        = 32,
  parameter int BCLK_HALF_PERIOD = 8,
  parameter int MCLK_HALF_PERIOD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    in_stb,
  output logic                    in_ack,
  output logic                    mclk_out,
  output logic                    bclk_out,
  output logic                    lrclk_out,
  output logic                    sdata_out,
  output logic                    frame_stb_out,
  output logic                    underrun_out
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int BDW = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;
  localparam int MDW = (MCLK_HALF_PERIOD > 1) ? $clog2(MCLK_HALF_PERIOD) : 1;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] l;
    logic [SAMPLE_WIDTH-1:0] r;
  } pair_t;

  logic [MDW-1:0]        mclk_cnt;
  logic [BDW-1:0]        bclk_cnt;
  logic [BW-1:0]         b, b_nxt;
  logic [FRAME_BITS-1:0] shreg, frame_word;
  pair_t                 buf_pair, last_pair, play_pair;
  logic                  buf_full, buf_full_nxt;
  logic                  bclk_tc, fall_ev, frame_start, accept;

  assign bclk_tc     = (bclk_cnt == BDW'(BCLK_HALF_PERIOD - 1));
  assign fall_ev     = bclk_tc && bclk_out;
  assign frame_start = fall_ev && (b == BW'(FRAME_BITS - 1));
  assign b_nxt       = (b == BW'(FRAME_BITS - 1)) ? '0 : b + 1'b1;
  assign accept      = in_stb && in_ack;

  // A pair accepted on the frame-start cycle lands in the buffer for the next frame.
  assign buf_full_nxt = frame_start ? accept : (buf_full || accept);
  assign play_pair    = buf_full ? buf_pair : last_pair;

  always_comb begin
    frame_word = '0;
    frame_word[FRAME_BITS-1 -: SAMPLE_WIDTH] = play_pair.l;
    frame_word[SLOT_BITS-1  -: SAMPLE_WIDTH] = play_pair.r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk_cnt <= '0;
      mclk_out <= 1'b0;
    end else if (mclk_cnt == MDW'(MCLK_HALF_PERIOD - 1)) begin
      mclk_cnt <= '0;
      mclk_out <= ~mclk_out;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_cnt <= '0;
      bclk_out <= 1'b0;
    end else if (bclk_tc) begin
      bclk_cnt <= '0;
      bclk_out <= ~bclk_out;
    end else begin
      bclk_cnt <= bclk_cnt + 1'b1;
    end
  end

  // Data and word select move only on the bclk falling event so the DAC sees
  // them stable at the following rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b             <= BW'(FRAME_BITS - 1);
      shreg         <= '0;
      sdata_out     <= 1'b0;
      lrclk_out     <= 1'b0;
      frame_stb_out <= 1'b0;
      underrun_out  <= 1'b0;
    end else begin
      frame_stb_out <= frame_start;
      underrun_out  <= frame_start && !buf_full;
      if (fall_ev) begin
        b         <= b_nxt;
        lrclk_out <= (b_nxt >= BW'(SLOT_BITS - 1)) && (b_nxt <= BW'(FRAME_BITS - 2));
        if (frame_start) begin
          sdata_out <= frame_word[FRAME_BITS-1];
          shreg     <= {frame_word[FRAME_BITS-2:0], 1'b0};
        end else begin
          sdata_out <= shreg[FRAME_BITS-1];
          shreg     <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_pair  <= '0;
      last_pair <= '0;
      buf_full  <= 1'b0;
      in_ack    <= 1'b0;
    end else begin
      buf_full <= buf_full_nxt;
      in_ack   <= !buf_full_nxt;
      if (accept)                  buf_pair  <= '{l: left_in, r: right_in};
      if (frame_start && buf_full) last_pair <= buf_pair;
    end
  end

endmodule
